// File: rtl/sram_sched_pkg.sv
// rtl/sram_sched_pkg.sv - shared state encoding and slot numbers for the SRAM slot scheduler
package sram_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BG_A,
        ST_BG_B,
        ST_H_A,
        ST_H_B,
        ST_H_C
    } state_e;

    localparam logic [2:0] SLOT_UNSYNC    = 3'd0;
    localparam logic [2:0] SLOT_BG_GNT    = 3'd1;
    localparam logic [2:0] SLOT_HOST_GNT  = 3'd4;
    localparam logic [2:0] SLOT_HOST_STRB = 3'd5;
    localparam logic [2:0] SLOT_HOST_END  = 3'd7;

endpackage

// File: rtl/sram_slot_decode.sv
// rtl/sram_slot_decode.sv - decodes the 7M slot counter into grant, strobe and end qualifiers
module sram_slot_decode
    import sram_sched_pkg::*;
(
    input  logic [2:0] s_i,
    output logic       bg_gnt_o,
    output logic       host_gnt_o,
    output logic       host_strb_o,
    output logic       host_end_o,
    output logic       unsync_o
);

    assign bg_gnt_o    = (s_i == SLOT_BG_GNT);
    assign host_gnt_o  = (s_i == SLOT_HOST_GNT);
    assign host_strb_o = (s_i == SLOT_HOST_STRB);
    assign host_end_o  = (s_i == SLOT_HOST_END);
    assign unsync_o    = (s_i == SLOT_UNSYNC);

endmodule

// File: rtl/sram_slot_sched.sv
// rtl/sram_slot_sched.sv - shares the SRAM bus between host (PHI0 half) and background (PHI1 half)
// Define SRAM_SCHED_BG_HOSTIDLE_EN to let background use an unclaimed host window.
module sram_slot_sched
    import sram_sched_pkg::*;
#(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 8
) (
    input  logic              C7M,
    input  logic              RES,
    input  logic [2:0]        S,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_done,
    input  logic              bg_req,
    input  logic              bg_we,
    input  logic [ADDR_W-1:0] bg_addr,
    input  logic [DATA_W-1:0] bg_wdata,
    output logic [DATA_W-1:0] bg_rdata,
    output logic              bg_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_cs,
    output logic              mem_oe,
    output logic              mem_we
);

    logic bg_gnt, host_gnt, host_strb, host_end, unsync;
    logic bg_host_win, host_abort;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_cs_q, mem_cs_d, mem_oe_q, mem_oe_d, mem_we_q, mem_we_d;
    logic              op_we_q, op_we_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d, bg_rdata_q, bg_rdata_d;
    logic              host_done_q, host_done_d, bg_ack_q, bg_ack_d;

    sram_slot_decode u_decode (
        .s_i        (S),
        .bg_gnt_o   (bg_gnt),
        .host_gnt_o (host_gnt),
        .host_strb_o(host_strb),
        .host_end_o (host_end),
        .unsync_o   (unsync)
    );

`ifdef SRAM_SCHED_BG_HOSTIDLE_EN
    assign bg_host_win = host_gnt & ~host_req;
`else
    assign bg_host_win = 1'b0;
`endif

    // An S1 edge during a host access means the slot counter resynchronised under us.
    assign host_abort = bg_gnt && (state_q == ST_H_A || state_q == ST_H_B || state_q == ST_H_C);

    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_cs_d     = mem_cs_q;
        mem_oe_d     = mem_oe_q;
        mem_we_d     = mem_we_q;
        op_we_d      = op_we_q;
        host_rdata_d = host_rdata_q;
        bg_rdata_d   = bg_rdata_q;
        host_done_d  = 1'b0;
        bg_ack_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (host_gnt && host_req) begin
                    state_d     = ST_H_A;
                    mem_addr_d  = host_addr;
                    mem_wdata_d = host_wdata;
                    mem_cs_d    = ~host_we;
                    mem_oe_d    = ~host_we;
                    mem_we_d    = 1'b0;
                    op_we_d     = host_we;
                end else if (bg_req && (bg_gnt || unsync || bg_host_win)) begin
                    state_d     = ST_BG_A;
                    mem_addr_d  = bg_addr;
                    mem_wdata_d = bg_wdata;
                    mem_cs_d    = 1'b1;
                    mem_oe_d    = ~bg_we;
                    mem_we_d    = 1'b0;
                    op_we_d     = bg_we;
                end
            end
            ST_BG_A: begin
                mem_we_d = op_we_q;
                state_d  = ST_BG_B;
            end
            ST_BG_B: begin
                if (!op_we_q) bg_rdata_d = mem_rdata;
                bg_ack_d = 1'b1;
                mem_cs_d = 1'b0;
                mem_oe_d = 1'b0;
                mem_we_d = 1'b0;
                state_d  = ST_IDLE;
            end
            ST_H_A: begin
                if (host_strb) begin
                    mem_cs_d = 1'b1;
                    mem_we_d = op_we_q;
                    state_d  = ST_H_B;
                end
            end
            ST_H_B: state_d = ST_H_C;
            ST_H_C: begin
                if (host_end) begin
                    if (!op_we_q) host_rdata_d = mem_rdata;
                    host_done_d = 1'b1;
                    mem_cs_d    = 1'b0;
                    mem_oe_d    = 1'b0;
                    mem_we_d    = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (host_abort) begin
            state_d     = ST_IDLE;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
            mem_cs_d    = 1'b0;
            mem_oe_d    = 1'b0;
            mem_we_d    = 1'b0;
            host_done_d = 1'b0;
        end
    end

    always_ff @(posedge C7M or posedge RES) begin
        if (RES) begin
            state_q      <= ST_IDLE;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_cs_q     <= 1'b0;
            mem_oe_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            op_we_q      <= 1'b0;
            host_rdata_q <= '0;
            bg_rdata_q   <= '0;
            host_done_q  <= 1'b0;
            bg_ack_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_cs_q     <= mem_cs_d;
            mem_oe_q     <= mem_oe_d;
            mem_we_q     <= mem_we_d;
            op_we_q      <= op_we_d;
            host_rdata_q <= host_rdata_d;
            bg_rdata_q   <= bg_rdata_d;
            host_done_q  <= host_done_d;
            bg_ack_q     <= bg_ack_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_cs     = mem_cs_q;
    assign mem_oe     = mem_oe_q;
    assign mem_we     = mem_we_q;
    assign host_rdata = host_rdata_q;
    assign host_done  = host_done_q;
    assign bg_rdata   = bg_rdata_q;
    assign bg_ack     = bg_ack_q;

endmodule
